// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the transmitter and the matching receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Oversampling ticks per bit period.
   localparam int          TICKS_PER_BIT = 16;
   localparam logic [3:0]  TICK_LAST     = 4'(TICKS_PER_BIT - 1);

endpackage

// File: rtl/baud_rate_gen.sv
// Oversampling tick generator: one-cycle o_tick every DIV clocks, where
// DIV = CLK_FREQ / (BAUD_RATE * 16). i_clear holds the phase at zero so a
// new frame always starts with a full tick interval.
module baud_rate_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int DIV = CLK_FREQ / (BAUD_RATE * TICKS_PER_BIT);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   logic [CW-1:0] r_div_cnt;

   // Divider counter: wraps at DIV-1, held at zero while cleared or in reset.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + CW'(1);
      end
   end

   assign o_tick = !i_clear && (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style framing (start bit, NB_DATA data bits LSB
// first, SB_TICK-tick stop period) with a ready/valid request handshake and
// a one-cycle o_done pulse on the last cycle of each frame.
module uart_tx
   import uart_pkg::*;
#(
   parameter int NB_DATA   = 8,
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 9600,
   parameter int SB_TICK   = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   output logic               o_tx,
   output logic               o_ready,
   output logic               o_done
);

   localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);
   localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);

   uart_state_t        r_state, w_state_next;
   logic [3:0]         r_tick_cnt, w_tick_cnt_next;
   logic [BW-1:0]      r_bit_cnt, w_bit_cnt_next;
   logic [NB_DATA-1:0] r_shift, w_shift_next;
   logic               w_tick;
   logic               w_clear;

   // The tick phase restarts at every acceptance because it is held in IDLE.
   assign w_clear = (r_state == IDLE);

   baud_rate_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_baud_rate_gen (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   // State, counters and shift register; reset aborts any frame in flight.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_tick_cnt <= w_tick_cnt_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_shift    <= w_shift_next;
      end
   end

   // Next-state, datapath updates and line/handshake outputs.
   always_comb begin
      w_state_next    = r_state;
      w_tick_cnt_next = r_tick_cnt;
      w_bit_cnt_next  = r_bit_cnt;
      w_shift_next    = r_shift;
      o_tx            = 1'b1;
      o_ready         = 1'b0;
      o_done          = 1'b0;

      unique case (r_state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               w_shift_next    = i_data;
               w_tick_cnt_next = '0;
               w_bit_cnt_next  = '0;
               w_state_next    = START;
            end
         end
         START: begin
            o_tx = 1'b0;
            if (w_tick) begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_cnt_next = '0;
                  w_state_next    = DATA;
               end else begin
                  w_tick_cnt_next = r_tick_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            o_tx = r_shift[0];
            if (w_tick) begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_cnt_next = '0;
                  w_shift_next    = r_shift >> 1;
                  if (r_bit_cnt == BIT_LAST) begin
                     w_bit_cnt_next = '0;
                     w_state_next   = STOP;
                  end else begin
                     w_bit_cnt_next = r_bit_cnt + BW'(1);
                  end
               end else begin
                  w_tick_cnt_next = r_tick_cnt + 4'd1;
               end
            end
         end
         STOP: begin
            o_tx = 1'b1;
            if (w_tick) begin
               if (r_tick_cnt == STOP_LAST) begin
                  w_tick_cnt_next = '0;
                  o_done          = 1'b1;
                  w_state_next    = IDLE;
               end else begin
                  w_tick_cnt_next = r_tick_cnt + 4'd1;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame.
REQ-002 Parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 9600, line bit rate.
REQ-004 Parameter SB_TICK, default 16, stop-bit length in oversampling ticks; 16 gives one stop bit.
REQ-005 Port i_clock, input, 1, the single clock for the whole block.
REQ-006 Port i_reset, input, 1, synchronous active-high reset.
REQ-007 Port i_data, input, NB_DATA, byte to transmit, typically the ALU result.
REQ-008 Port i_valid, input, 1, transmit request, sampled on the rising edge of i_clock.
REQ-009 Port o_tx, output, 1, serial line, idle high.
REQ-010 Port o_ready, output, 1, high when a request will be accepted.
REQ-011 Port o_done, output, 1, one-cycle pulse at the end of a frame.

Function
REQ-012 Tick divisor DIV SHALL equal CLK_FREQ/(BAUD_RATE*16), integer-truncated; the default parameters give 651.
REQ-013 The tick generator SHALL emit a one-cycle tick every DIV clocks and SHALL be held cleared in IDLE, so timing starts fresh at each acceptance.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-015 IDLE: o_tx=1, o_ready=1; when i_valid=1, the block SHALL latch i_data into a shift register, clear the tick and bit counters, and go to START.
REQ-016 o_tx SHALL go low in the first cycle after the acceptance edge, which gives a latency of 1 clock.
REQ-017 START: o_tx=0 for 16 ticks, then go to DATA.
REQ-018 DATA: o_tx SHALL equal shift register bit 0, LSB first; after 16 ticks the register shifts right and the bit counter increments; after bit NB_DATA-1 completes, go to STOP.
REQ-019 STOP: o_tx=1 for SB_TICK ticks, then go to IDLE with o_done=1 for exactly that one transition cycle.
REQ-020 A frame SHALL last (16*(NB_DATA+1)+SB_TICK)*DIV clocks from the first low cycle to the o_done cycle.
REQ-021 o_ready SHALL be 0 in START, DATA and STOP.
REQ-022 While o_ready=0, i_valid SHALL be ignored; there is no queueing, and changes on i_data SHALL not affect the frame in flight.
REQ-023 Back-to-back: if i_valid=1 in the first IDLE cycle after o_done, the block SHALL accept it, with one idle-high cycle minimum between frames.
REQ-024 Tick counter width SHALL be 4 bits; the bit counter SHALL be clog2(NB_DATA) bits; the divider counter SHALL be clog2(DIV) bits.

Reset
REQ-025 While i_reset=1 at a clock edge, the block SHALL go to state IDLE with o_tx=1, o_ready=1, o_done=0, and all counters and the shift register at 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately: o_tx=1 on the next edge, no o_done, and i_valid ignored while reset is asserted.
REQ-027 Reset has priority over i_valid in the same cycle.

Structure
REQ-028 FSM state encoding and the tick constant 16 SHALL live in the shared package uart_pkg, for reuse by the matching uart_rx.
REQ-029 The tick generator SHALL be a sub-module named baud_rate_gen, with ports i_clock, i_reset, i_clear and o_tick.
REQ-030 uart_tx SHALL instantiate baud_rate_gen and contain the FSM and the datapath.

Verification
All scenarios use CLK_FREQ=1600, BAUD_RATE=100, so DIV=1 and each bit lasts 16 clocks.
REQ-031 Single frame: i_data=0x55, i_valid pulse -> o_tx reads 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit held 16 clocks; o_done pulses at clock 160 after the first low cycle.
REQ-032 Extremes: 0x00, then 0xFF -> 9 low bit periods then stop for 0x00; 1 low bit period then 9 high for 0xFF; o_ready low throughout each frame.
REQ-033 Ignore while busy: accept 0xA3, pulse i_valid with 0x5C at clock 40 -> wire carries only 0xA3; no second frame follows.
REQ-034 Back-to-back: i_valid held high with 0x12, then 0x34 -> two frames, each 160 clocks, separated by exactly one idle-high cycle.
REQ-035 Reset mid-frame: assert i_reset at clock 70 of a 0xC7 frame -> o_tx=1, o_ready=1 next edge, no o_done; a following 0x81 frame is transmitted correctly.
REQ-036 Default parameters, 0x3C: start bit measured at 651*16=10416 clocks.
